// File: rtl/fir_pkg.sv
// Types and defaults shared by the FIR delay line (shiftReg) and the frame serializer.
package fir_pkg;
    localparam int FIR_DATA_WIDTH = 16;
    localparam int FIR_NUM_REGS   = 8;

    typedef logic [FIR_DATA_WIDTH-1:0] sample_t;
    typedef sample_t frame_t [0:FIR_NUM_REGS-1];

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;
endpackage

// File: rtl/piso_serializer_frame_buf.sv
// Frame buffer: loads all entries in one cycle, reads one entry by index.
module frame_buf #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8,
    parameter int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] din [0:NUM_REGS-1],
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem_q [0:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] mem_d [0:NUM_REGS-1];

    always_comb begin
        mem_d = mem_q;
        if (load) begin
            mem_d = din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_idx];
endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out frame serializer, oldest sample (highest index) first.
module piso_serializer
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = FIR_DATA_WIDTH,
    parameter int NUM_REGS   = FIR_NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pValid,
    output logic                  pReady,
    input  logic [DATA_WIDTH-1:0] pDataIn [0:NUM_REGS-1],
    output logic                  sValid,
    input  logic                  sReady,
    output logic [DATA_WIDTH-1:0] sDataOut,
    output logic                  sLast,
    output logic                  busy
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    ser_state_t            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  s_valid_q, s_valid_d;
    logic                  s_last_q, s_last_d;
    logic [DATA_WIDTH-1:0] s_data_q, s_data_d;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [IDX_W-1:0]      rd_idx;
    logic                  load;
    logic                  hs;

    // Finishing a frame frees the buffer in the same cycle, so the next frame lands without a bubble.
    assign pReady = rst && ((state_q == IDLE) || (s_valid_q && sReady && s_last_q));
    assign load   = pValid && pReady;
    assign hs     = s_valid_q && sReady;
    assign rd_idx = idx_q - IDX_W'(1);

    frame_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_frame_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .din     (pDataIn),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        s_valid_d = s_valid_q;
        s_last_d  = s_last_q;
        s_data_d  = s_data_q;
        if (load) begin
            state_d   = SHIFT;
            idx_d     = LAST_IDX;
            s_valid_d = 1'b1;
            s_last_d  = 1'b0;
            s_data_d  = pDataIn[NUM_REGS-1];
        end else if (state_q == SHIFT && hs) begin
            if (idx_q == '0) begin
                state_d   = IDLE;
                s_valid_d = 1'b0;
                s_last_d  = 1'b0;
            end else begin
                idx_d    = rd_idx;
                s_data_d = rd_data;
                s_last_d = (rd_idx == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            s_valid_q <= 1'b0;
            s_last_q  <= 1'b0;
            s_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            s_valid_q <= s_valid_d;
            s_last_q  <= s_last_d;
            s_data_q  <= s_data_d;
        end
    end

    assign sValid   = s_valid_q;
    assign sLast    = s_last_q;
    assign sDataOut = s_data_q;
    assign busy     = (state_q == SHIFT);
endmodule
